// File: rtl/corelet_pkg.sv
// Shared types and constants for the corelet issue-side sequencer.
package corelet_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam logic [1:0] INST_IDLE = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

  localparam int KIJ_DEFAULT = 9;

endpackage

// File: rtl/corelet_seq_addr_gen.sv
// XMEM fetch address generator: issues base+offset reads during FILL and
// produces the L0 write strobe one cycle behind each issue.
module corelet_seq_addr_gen
  import corelet_pkg::*;
#(
  parameter int XMEM_ADDR_W = 11,
  parameter int LEN_W       = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_clr,
  input  logic                   i_en,
  input  logic [XMEM_ADDR_W-1:0] i_base,
  input  logic [LEN_W-1:0]       i_len,
  output logic                   o_cen,
  output logic [XMEM_ADDR_W-1:0] o_addr,
  output logic                   o_l0_wr,
  output logic                   o_tail
);

  logic [LEN_W-1:0] r_off;
  logic             r_wr;
  logic             w_issue;

  // Once every word is issued the offset parks at len, which marks the tail cycle.
  assign w_issue = i_en && (r_off != i_len);
  assign o_tail  = i_en && (r_off == i_len);
  assign o_cen   = ~w_issue;
  assign o_addr  = w_issue ? (i_base + XMEM_ADDR_W'(r_off)) : '0;
  assign o_l0_wr = r_wr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_off <= '0;
      r_wr  <= 1'b0;
    end else begin
      r_wr <= w_issue;
      if (i_clr) begin
        r_off <= '0;
      end else if (w_issue) begin
        r_off <= r_off + LEN_W'(1);
      end
    end
  end

endmodule

// File: rtl/corelet_seq.sv
// Corelet tile-pass sequencer: XMEM->L0 fill, L0->array replay, OFIFO drain.
// Optional drain stall counter enabled by defining CORELET_SEQ_PERF_EN.
module corelet_seq
  import corelet_pkg::*;
#(
  parameter int XMEM_ADDR_W = 11,
  parameter int LEN_W       = 6,
  parameter int KIJ         = KIJ_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   mode,
  input  logic [XMEM_ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]       len,
  output logic                   xmem_cen,
  output logic [XMEM_ADDR_W-1:0] xmem_addr,
  output logic                   l0_wr,
  output logic                   l0_rd,
  input  logic                   l0_full,
  output logic [1:0]             inst_w,
  input  logic                   ofifo_valid,
  output logic                   ofifo_rd,
  output logic [3:0]             kij_idx,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [15:0]            drain_wait
);

  state_t                 r_state, w_next;
  logic                   r_mode;
  logic [XMEM_ADDR_W-1:0] r_base;
  logic [LEN_W-1:0]       r_len;
  logic [LEN_W-1:0]       r_cnt;
  logic [3:0]             r_kij;
  logic                   r_err;
  logic                   w_accept, w_row, w_last, w_tail, w_l0_wr;

  assign w_accept = (r_state == IDLE) && start;
  assign ofifo_rd = ofifo_valid && (r_state == DRAIN);
  assign w_row    = ofifo_rd;
  assign w_last   = (r_cnt == (r_len - LEN_W'(1)));
  assign l0_wr    = w_l0_wr;
  assign kij_idx  = r_kij;
  assign err      = r_err;

  corelet_seq_addr_gen #(
    .XMEM_ADDR_W(XMEM_ADDR_W),
    .LEN_W      (LEN_W)
  ) u_addr_gen (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_accept),
    .i_en   (r_state == FILL),
    .i_base (r_base),
    .i_len  (r_len),
    .o_cen  (xmem_cen),
    .o_addr (xmem_addr),
    .o_l0_wr(w_l0_wr),
    .o_tail (w_tail)
  );

  always_comb begin
    w_next = r_state;
    l0_rd  = 1'b0;
    inst_w = INST_IDLE;
    busy   = 1'b1;
    done   = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_next = (len == '0) ? DONE : FILL;
      end
      FILL: if (w_tail) w_next = RUN;
      RUN: begin
        l0_rd  = 1'b1;
        inst_w = r_mode ? INST_EXEC : INST_LOAD;
        if (w_last) w_next = r_mode ? DRAIN : DONE;
      end
      DRAIN: if (w_row && w_last) w_next = DONE;
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // r_cnt is shared by RUN (cycles) and DRAIN (rows); it restarts on every state change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_kij   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_cnt <= '0;
      end else if ((r_state == RUN) || w_row) begin
        r_cnt <= r_cnt + LEN_W'(1);
      end
      if (w_l0_wr && l0_full) r_err <= 1'b1;
      if ((r_state == DONE) && r_mode) begin
        r_kij <= (r_kij == 4'(KIJ - 1)) ? 4'd0 : r_kij + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mode <= mode;
      r_base <= base_addr;
      r_len  <= len;
    end
  end

`ifdef CORELET_SEQ_PERF_EN
  logic [15:0] r_drain_wait;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_drain_wait <= '0;
    end else if (w_accept) begin
      r_drain_wait <= '0;
    end else if ((r_state == DRAIN) && !ofifo_valid && (r_drain_wait != 16'hFFFF)) begin
      r_drain_wait <= r_drain_wait + 16'd1;
    end
  end

  assign drain_wait = r_drain_wait;
`else
  assign drain_wait = 16'd0;
`endif

endmodule
